// File: rtl/abs_max_min_pkg.sv
// Shared mode codes and running-frame FSM encoding for the abs/max/min pipeline.
package abs_max_min_pkg;

  localparam logic [2:0] MODE_ABS     = 3'd0;
  localparam logic [2:0] MODE_MAX     = 3'd1;
  localparam logic [2:0] MODE_MIN     = 3'd2;
  localparam logic [2:0] MODE_SUB     = 3'd3;
  localparam logic [2:0] MODE_RUN_MAX = 3'd4;
  localparam logic [2:0] MODE_RUN_MIN = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } run_state_e;

endpackage

// File: rtl/sat_sub.sv
// WIDTH+1-bit subtractor A-B with saturation to the signed or unsigned WIDTH-bit range.
module sat_sub #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   diff_o,
  output logic [WIDTH-1:0] sat_o,
  output logic             sat_flag_o,
  output logic             lt_o
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic a_ext;
  logic b_ext;

  assign a_ext  = SIGNED ? a_i[WIDTH-1] : 1'b0;
  assign b_ext  = SIGNED ? b_i[WIDTH-1] : 1'b0;
  assign diff_o = {a_ext, a_i} - {b_ext, b_i};

  // The extra bit makes the difference exact, so its MSB is the true sign / borrow.
  assign lt_o = diff_o[WIDTH];

  always_comb begin
    sat_o      = diff_o[WIDTH-1:0];
    sat_flag_o = 1'b0;
    if (SIGNED) begin
      if (diff_o[WIDTH] != diff_o[WIDTH-1]) begin
        sat_flag_o = 1'b1;
        sat_o      = diff_o[WIDTH] ? SMIN : SMAX;
      end
    end else if (diff_o[WIDTH]) begin
      sat_flag_o = 1'b1;
      sat_o      = '0;
    end
  end

endmodule

// File: rtl/abs_max_min_pipe.sv
// Two-stage ABS/MAX/MIN/SUB pipeline with running max/min frames and valid/ready flow control.
//   state    | meaning
//   ST_IDLE  | no open running frame; beats decoded by their own mode
//   ST_ACCUM | running frame open; every beat folds A into acc with the latched mode
module abs_max_min_pipe
  import abs_max_min_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_sel,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_flag,
  output logic             out_last
);

  logic             s2_adv;
  logic             s1_adv;
  logic             s1_fire;

  logic [WIDTH:0]   sub_diff;
  logic [WIDTH-1:0] sub_sat;
  logic             sub_satf;
  logic             sub_lt;

  logic             s1_v_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       mode_q;
  logic             last_in_q;
  logic [WIDTH:0]   diff_q;
  logic [WIDTH-1:0] sat_q;
  logic             satf_q;
  logic             lt_q;

  run_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             fmax_q, fmax_d;

  logic             s2_v_q, s2_v_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             flag_q, flag_d;
  logic             olast_q, olast_d;

  logic [WIDTH-1:0] abs_val;
  logic             gt_s1;
  logic [WIDTH-1:0] run_pick;

  function automatic logic less(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    if (SIGNED) return $signed(x) < $signed(y);
    else        return x < y;
  endfunction

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign s1_fire  = s1_v_q && s2_adv;
  assign in_ready = s1_adv;

  sat_sub #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_sat_sub (
    .a_i        (in_a),
    .b_i        (in_b),
    .diff_o     (sub_diff),
    .sat_o      (sub_sat),
    .sat_flag_o (sub_satf),
    .lt_o       (sub_lt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= MODE_ABS;
      last_in_q <= 1'b0;
      diff_q    <= '0;
      sat_q     <= '0;
      satf_q    <= 1'b0;
      lt_q      <= 1'b0;
    end else if (s1_adv) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        a_q       <= in_a;
        b_q       <= in_b;
        mode_q    <= in_sel;
        last_in_q <= in_last;
        diff_q    <= sub_diff;
        sat_q     <= sub_sat;
        satf_q    <= sub_satf;
        lt_q      <= sub_lt;
      end
    end
  end

  // |A-B| always fits WIDTH unsigned bits because the registered difference is exact.
  assign abs_val  = diff_q[WIDTH] ? (~diff_q[WIDTH-1:0] + WIDTH'(1)) : diff_q[WIDTH-1:0];
  assign gt_s1    = !diff_q[WIDTH] && (diff_q != '0);
  assign run_pick = fmax_q ? (less(acc_q, a_q) ? a_q : acc_q)
                           : (less(a_q, acc_q) ? a_q : acc_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (s1_fire) begin
      case (state_q)
        ST_IDLE: begin
          if ((mode_q == MODE_RUN_MAX || mode_q == MODE_RUN_MIN) && !last_in_q)
            state_d = ST_ACCUM;
        end
        ST_ACCUM: begin
          if (last_in_q) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    s2_v_d  = s2_adv ? 1'b0 : s2_v_q;
    res_d   = res_q;
    flag_d  = flag_q;
    olast_d = olast_q;
    acc_d   = acc_q;
    fmax_d  = fmax_q;
    if (s1_fire) begin
      if (state_q == ST_ACCUM) begin
        acc_d = run_pick;
        if (last_in_q) begin
          s2_v_d  = 1'b1;
          res_d   = run_pick;
          flag_d  = 1'b0;
          olast_d = 1'b1;
        end
      end else begin
        case (mode_q)
          MODE_ABS: begin
            s2_v_d  = 1'b1;
            res_d   = abs_val;
            flag_d  = 1'b0;
            olast_d = 1'b0;
          end
          MODE_MAX: begin
            s2_v_d  = 1'b1;
            res_d   = lt_q ? b_q : a_q;
            flag_d  = 1'b0;
            olast_d = 1'b0;
          end
          MODE_MIN: begin
            s2_v_d  = 1'b1;
            res_d   = gt_s1 ? b_q : a_q;
            flag_d  = 1'b0;
            olast_d = 1'b0;
          end
          MODE_SUB: begin
            s2_v_d  = 1'b1;
            res_d   = sat_q;
            flag_d  = satf_q;
            olast_d = 1'b0;
          end
          MODE_RUN_MAX, MODE_RUN_MIN: begin
            if (last_in_q) begin
              s2_v_d  = 1'b1;
              res_d   = a_q;
              flag_d  = 1'b0;
              olast_d = 1'b1;
            end else begin
              acc_d  = a_q;
              fmax_d = (mode_q == MODE_RUN_MAX);
            end
          end
          default: begin
            s2_v_d  = 1'b1;
            res_d   = '0;
            flag_d  = 1'b1;
            olast_d = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v_q  <= 1'b0;
      res_q   <= '0;
      flag_q  <= 1'b0;
      olast_q <= 1'b0;
      acc_q   <= '0;
      fmax_q  <= 1'b0;
    end else begin
      s2_v_q  <= s2_v_d;
      res_q   <= res_d;
      flag_q  <= flag_d;
      olast_q <= olast_d;
      acc_q   <= acc_d;
      fmax_q  <= fmax_d;
    end
  end

  assign out_valid  = s2_v_q;
  assign out_result = res_q;
  assign out_flag   = flag_q;
  assign out_last   = olast_q;

endmodule
